// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_send transmitter among NUM_REQ byte sources.
// Optional packet lock (message-atomic arbitration) is enabled by defining UART_ARB_PKT_LOCK_EN.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int BUSY_WAIT = 4,
    parameter int CNT_W     = 16,
    localparam int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                 sys_clk,
    input  logic                 sys_rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 uart_en,
    output logic [7:0]           uart_din,
    input  logic                 uart_tx_busy,
    output logic [ID_W-1:0]      grant_id,
    output logic                 active,
    output logic [CNT_W-1:0]     byte_cnt,
    output logic                 timeout_err
);

    localparam int WAIT_W = $clog2(BUSY_WAIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_HI,
        WAIT_LO
    } state_t;

    state_t              state;
    state_t              state_d;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     ptr_d;
    logic [WAIT_W-1:0]   wait_q;
    logic [WAIT_W-1:0]   wait_d;
    logic [7:0]          din_d;
    logic [ID_W-1:0]     gid_d;
    logic                en_d;
    logic [NUM_REQ-1:0]  ready_d;
    logic [CNT_W-1:0]    bcnt_d;
    logic                terr_d;
    logic                active_d;

    logic [NUM_REQ-1:0]  eligible;
    logic                found;
    logic [ID_W-1:0]     winner;
    int                  idx;

`ifdef UART_ARB_PKT_LOCK_EN
    logic lock_q;
    logic lock_d;
    logic last_q;
    logic last_d;

    // While locked, only the owner of the message in flight may be granted.
    assign eligible = lock_q ? (req_valid & (NUM_REQ'(1) << grant_id)) : req_valid;
`else
    logic unused_last;

    assign unused_last = ^req_last;
    assign eligible    = req_valid;
`endif

    // Search starts one past the last completed grant so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && eligible[ID_W'(idx)]) begin
                found  = 1'b1;
                winner = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state;
        ptr_d   = rr_ptr;
        wait_d  = wait_q;
        din_d   = uart_din;
        gid_d   = grant_id;
        en_d    = 1'b0;
        ready_d = '0;
        bcnt_d  = byte_cnt;
        terr_d  = timeout_err;
`ifdef UART_ARB_PKT_LOCK_EN
        lock_d  = lock_q;
        last_d  = last_q;
`endif
        case (state)
            IDLE: begin
                if (found && !uart_tx_busy) begin
                    state_d = ISSUE;
                    din_d   = req_data[{winner, 3'b000} +: 8];
                    gid_d   = winner;
                    en_d    = 1'b1;
                    ready_d = NUM_REQ'(1) << winner;
`ifdef UART_ARB_PKT_LOCK_EN
                    lock_d  = ~req_last[winner];
                    last_d  = req_last[winner];
`endif
                end
            end
            ISSUE: begin
                state_d = WAIT_HI;
                wait_d  = '0;
            end
            WAIT_HI: begin
                if (uart_tx_busy) begin
                    state_d = WAIT_LO;
                end else if (wait_q == WAIT_W'(BUSY_WAIT - 1)) begin
                    // Transmitter never acknowledged the start pulse; give up on this byte.
                    state_d = IDLE;
                    terr_d  = 1'b1;
`ifdef UART_ARB_PKT_LOCK_EN
                    lock_d  = 1'b0;
`endif
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            WAIT_LO: begin
                if (!uart_tx_busy) begin
                    state_d = IDLE;
                    bcnt_d  = byte_cnt + CNT_W'(1);
`ifdef UART_ARB_PKT_LOCK_EN
                    if (last_q) begin
                        ptr_d  = grant_id;
                        lock_d = 1'b0;
                    end
`else
                    ptr_d   = grant_id;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        active_d = (state_d != IDLE);
    end

    // Every output is a flop loaded from its next-state value.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            rr_ptr      <= ID_W'(NUM_REQ - 1);
            wait_q      <= '0;
            uart_din    <= '0;
            grant_id    <= '0;
            uart_en     <= 1'b0;
            req_ready   <= '0;
            byte_cnt    <= '0;
            timeout_err <= 1'b0;
            active      <= 1'b0;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q      <= 1'b0;
            last_q      <= 1'b0;
`endif
        end else begin
            state       <= state_d;
            rr_ptr      <= ptr_d;
            wait_q      <= wait_d;
            uart_din    <= din_d;
            grant_id    <= gid_d;
            uart_en     <= en_d;
            req_ready   <= ready_d;
            byte_cnt    <= bcnt_d;
            timeout_err <= terr_d;
            active      <= active_d;
`ifdef UART_ARB_PKT_LOCK_EN
            lock_q      <= lock_d;
            last_q      <= last_d;
`endif
        end
    end

endmodule
